mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store port
// share one memory bus with at most one transaction outstanding. The data port
// normally wins. After STARVE_LIMIT consecutive data grants with a fetch
// waiting, the fetch port wins the next arbitration.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction fetch port
    input  logic        imem_req_i,
    input  logic [63:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,
    // load/store port
    input  logic        dmem_req_i,
    input  logic        dmem_we_i,
    input  logic [7:0]  dmem_be_i,
    input  logic [63:0] dmem_addr_i,
    input  logic [63:0] dmem_wdata_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [63:0] dmem_rdata_o,
    // shared memory bus
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_be_o,
    output logic [63:0] bus_addr_o,
    output logic [63:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [63:0] bus_rdata_i,
    output logic        busy_o
);

    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           lock_q, lock_d;         // selection frozen until bus grant
    logic           lock_sel_i_q, lock_sel_i_d;
    logic           hi_q, hi_d;             // fetch addr[2]: which 32-bit half
    logic           any_req;
    logic           sel_i;                  // 1 = fetch port owns the request

    // Arbitration: a pending unaccepted request keeps its owner; otherwise the
    // data port wins unless the fetch port has been starved long enough.
    always_comb begin
        any_req = imem_req_i | dmem_req_i;
        if (lock_q) begin
            sel_i = lock_sel_i_q;
        end else begin
            sel_i = imem_req_i & (~dmem_req_i | (starve_q == LIMIT));
        end
    end

    // Output decode; every output is forced low while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_be_o      = 8'h00;
        bus_addr_o    = 64'h0;
        bus_wdata_o   = 64'h0;
        imem_gnt_o    = 1'b0;
        dmem_gnt_o    = 1'b0;
        imem_rvalid_o = 1'b0;
        dmem_rvalid_o = 1'b0;
        imem_rdata_o  = 32'h0;
        dmem_rdata_o  = 64'h0;
        busy_o        = 1'b0;
        if (!rst_i) begin
            imem_rdata_o = hi_q ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
            dmem_rdata_o = bus_rdata_i;
            unique case (state_q)
                IDLE: begin
                    bus_req_o = any_req;
                    if (sel_i) begin
                        bus_we_o    = 1'b0;
                        bus_be_o    = 8'hFF;
                        bus_addr_o  = imem_addr_i;
                        bus_wdata_o = 64'h0;
                    end else begin
                        bus_we_o    = dmem_we_i;
                        bus_be_o    = dmem_be_i;
                        bus_addr_o  = dmem_addr_i;
                        bus_wdata_o = dmem_wdata_i;
                    end
                    imem_gnt_o = any_req & bus_gnt_i & sel_i;
                    dmem_gnt_o = any_req & bus_gnt_i & ~sel_i;
                end
                WAIT_I: begin
                    busy_o        = 1'b1;
                    imem_rvalid_o = bus_rvalid_i;
                end
                WAIT_D: begin
                    busy_o        = 1'b1;
                    dmem_rvalid_o = bus_rvalid_i;
                end
                default: ;
            endcase
        end
    end

    // Next-state, selection lock, fetch half-select and starvation counter.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        lock_d       = lock_q;
        lock_sel_i_d = lock_sel_i_q;
        hi_d         = hi_q;
        unique case (state_q)
            IDLE: begin
                if (any_req && bus_gnt_i) begin
                    lock_d = 1'b0;
                    if (sel_i) begin
                        state_d  = WAIT_I;
                        hi_d     = imem_addr_i[2];
                        starve_d = '0;
                    end else begin
                        state_d = WAIT_D;
                        if (!imem_req_i)            starve_d = '0;
                        else if (starve_q != LIMIT) starve_d = starve_q + CW'(1);
                    end
                end else begin
                    if (any_req) begin
                        lock_d       = 1'b1;
                        lock_sel_i_d = sel_i;
                    end
                    if (!imem_req_i) starve_d = '0;
                end
            end
            WAIT_I, WAIT_D: begin
                if (bus_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            lock_q       <= 1'b0;
            lock_sel_i_q <= 1'b0;
            hi_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            lock_q       <= lock_d;
            lock_sel_i_q <= lock_sel_i_d;
            hi_q         <= hi_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_i;
    logic [63:0] imem_addr_i;
    logic        imem_gnt_o, imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i, dmem_we_i;
    logic [7:0]  dmem_be_i;
    logic [63:0] dmem_addr_i, dmem_wdata_i;
    logic        dmem_gnt_o, dmem_rvalid_o;
    logic [63:0] dmem_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [7:0]  bus_be_o;
    logic [63:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    logic        busy_o;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_gnt_o(imem_gnt_o), .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_be_i(dmem_be_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_gnt_o(dmem_gnt_o), .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .busy_o(busy_o)
    );

    // ---------------- reference model ----------------
    // owner: 0 none, 1 fetch, 2 data. lock: 0 none, else the frozen owner.
    int   m_owner = 0;
    int   m_lock  = 0;
    int   m_streak = 0;   // data grants taken while a fetch was waiting
    logic m_hi = 1'b0;

    logic        e_req, e_sel_i, e_we, e_igrant, e_dgrant, e_irv, e_drv, e_busy;
    logic [7:0]  e_be;
    logic [63:0] e_addr, e_wdata;
    logic [31:0] e_irdata;

    function automatic logic [5:0] status();
        return {bus_req_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o, busy_o};
    endfunction

    function automatic void model_eval();
        e_req = 0; e_sel_i = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        e_igrant = 0; e_dgrant = 0; e_irv = 0; e_drv = 0; e_busy = 0;
        e_irdata = m_hi ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
        if (rst_i) return;
        if (m_owner == 0) begin
            e_req = imem_req_i || dmem_req_i;
            if (m_lock != 0) e_sel_i = (m_lock == 1);
            else             e_sel_i = imem_req_i && (!dmem_req_i || m_streak >= LIMIT);
            if (e_sel_i) begin
                e_be = 8'hFF; e_addr = imem_addr_i;
            end else begin
                e_we = dmem_we_i; e_be = dmem_be_i; e_addr = dmem_addr_i; e_wdata = dmem_wdata_i;
            end
            e_igrant = e_req && bus_gnt_i && e_sel_i;
            e_dgrant = e_req && bus_gnt_i && !e_sel_i;
        end else begin
            e_busy = 1;
            e_irv  = (m_owner == 1) && bus_rvalid_i;
            e_drv  = (m_owner == 2) && bus_rvalid_i;
        end
    endfunction

    // Advance one clock: evaluate model on the current inputs, then commit.
    task automatic tick();
        model_eval();
        @(posedge clk_i);
        if (rst_i) begin
            m_owner = 0; m_lock = 0; m_streak = 0; m_hi = 0;
        end else if (m_owner == 0) begin
            if (e_req && bus_gnt_i) begin
                m_owner = e_sel_i ? 1 : 2;
                m_lock  = 0;
                if (e_sel_i) begin
                    m_streak = 0;
                    m_hi     = imem_addr_i[2];
                end else begin
                    m_streak = imem_req_i ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                end
            end else begin
                if (e_req) m_lock = e_sel_i ? 1 : 2;
                if (!imem_req_i) m_streak = 0;
            end
        end else if (bus_rvalid_i) begin
            m_owner = 0;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1; imem_req_i = 1; imem_addr_i = 64'h40; dmem_req_i = 1; dmem_we_i = 1;
        dmem_be_i = 8'h0F; dmem_addr_i = 64'h80; dmem_wdata_i = 64'h1234;
        bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b0) $display("FAIL reset_status: got %b expected %b", status(), 6'b0);
        else passes++;
        checks++;
        if ({bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o} !== '0 || dmem_rdata_o !== 64'h0 || imem_rdata_o !== 32'h0)
            $display("FAIL reset_fields: addr %h rdata %h/%h expected all zero", bus_addr_o, dmem_rdata_o, imem_rdata_o);
        else passes++;
        tick(); tick();
        rst_i = 0; imem_req_i = 0; dmem_req_i = 0; dmem_we_i = 0; dmem_be_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b0) $display("FAIL reset_idle: got %b expected %b", status(), 6'b0);
        else passes++;
        tick();
    endtask

    task automatic test_single_fetch();
        imem_req_i = 1; imem_addr_i = 64'h1004; bus_gnt_i = 0;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b100000 || bus_addr_o !== 64'h1004 || bus_we_o !== 0 || bus_be_o !== 8'hFF || bus_wdata_o !== 64'h0)
            $display("FAIL fetch_req: status %b addr %h we %b be %h wdata %h expected 100000 1004 0 ff 0",
                     status(), bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o);
        else passes++;
        tick();
        bus_gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b110000) $display("FAIL fetch_gnt: got %b expected %b", status(), 6'b110000);
        else passes++;
        tick();
        imem_req_i = 0; bus_gnt_i = 0;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b000001) $display("FAIL fetch_busy: got %b expected %b", status(), 6'b000001);
        else passes++;
        tick();
        bus_rvalid_i = 1; bus_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b000101 || imem_rdata_o !== 32'hAAAA_BBBB)
            $display("FAIL fetch_rdata: status %b rdata %h expected 000101 aaaabbbb", status(), imem_rdata_o);
        else passes++;
        tick();
        bus_rvalid_i = 0;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b000000) $display("FAIL fetch_done: got %b expected %b", status(), 6'b0);
        else passes++;
        tick();
    endtask

    task automatic test_simultaneous();
        imem_req_i = 1; imem_addr_i = 64'h2000; dmem_req_i = 1; dmem_we_i = 0;
        dmem_be_i = 8'hF0; dmem_addr_i = 64'h3008; bus_gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b101000 || bus_addr_o !== 64'h3008 || bus_be_o !== 8'hF0)
            $display("FAIL simul_dgnt: status %b addr %h be %h expected 101000 3008 f0", status(), bus_addr_o, bus_be_o);
        else passes++;
        tick();
        dmem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b000011 || dmem_rdata_o !== 64'h0123_4567_89AB_CDEF)
            $display("FAIL simul_drv: status %b rdata %h expected 000011 0123456789abcdef", status(), dmem_rdata_o);
        else passes++;
        tick();
        bus_rvalid_i = 0; bus_gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b110000 || bus_addr_o !== 64'h2000)
            $display("FAIL simul_ignt: status %b addr %h expected 110000 2000", status(), bus_addr_o);
        else passes++;
        tick();
        imem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 64'h5555_6666_7777_8888;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b000101 || imem_rdata_o !== 32'h7777_8888)
            $display("FAIL simul_irv: status %b rdata %h expected 000101 77778888", status(), imem_rdata_o);
        else passes++;
        tick();
        bus_rvalid_i = 0;
        tick();
    endtask

    task automatic test_starvation();
        imem_req_i = 1; imem_addr_i = 64'h4000; dmem_req_i = 1; dmem_we_i = 1;
        dmem_be_i = 8'hFF; dmem_addr_i = 64'h5000; dmem_wdata_i = 64'hDEAD;
        for (int round = 0; round < 2; round++) begin
            int  dg;
            bit  got_i;
            dg = 0; got_i = 0;
            for (int k = 0; k < 12 && !got_i; k++) begin
                bus_gnt_i = 1; bus_rvalid_i = 0;
                @(negedge clk_i);
                if (imem_gnt_o) got_i = 1;
                else if (dmem_gnt_o) dg++;
                tick();
                bus_gnt_i = 0; bus_rvalid_i = 1;
                tick();
            end
            checks++;
            if (!got_i || dg != LIMIT)
                $display("FAIL starve_round%0d: data grants %0d fetch granted %0b expected %0d 1", round, dg, got_i, LIMIT);
            else passes++;
        end
        imem_req_i = 0; dmem_req_i = 0; bus_rvalid_i = 0;
        tick();
    endtask

    task automatic test_lock();
        imem_req_i = 1; imem_addr_i = 64'h6004; dmem_req_i = 0; bus_gnt_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                dmem_req_i = 1; dmem_addr_i = 64'h7000; dmem_we_i = 1; dmem_be_i = 8'h03;
            end
            @(negedge clk_i);
            checks++;
            if (status() !== 6'b100000 || bus_addr_o !== 64'h6004)
                $display("FAIL lock_hold%0d: status %b addr %h expected 100000 6004", c, status(), bus_addr_o);
            else passes++;
            tick();
        end
        bus_gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b110000 || bus_addr_o !== 64'h6004)
            $display("FAIL lock_gnt: status %b addr %h expected 110000 6004", status(), bus_addr_o);
        else passes++;
        tick();
        imem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1;
        tick();
        bus_rvalid_i = 0; bus_gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b101000 || bus_addr_o !== 64'h7000)
            $display("FAIL lock_dgnt: status %b addr %h expected 101000 7000", status(), bus_addr_o);
        else passes++;
        tick();
        dmem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1;
        tick();
        bus_rvalid_i = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        dmem_req_i = 1; dmem_we_i = 0; dmem_addr_i = 64'h8000; bus_gnt_i = 1;
        tick();
        dmem_req_i = 0; bus_gnt_i = 0; rst_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b0) $display("FAIL rstmid_outputs: got %b expected %b", status(), 6'b0);
        else passes++;
        tick();
        rst_i = 0; bus_rvalid_i = 1;
        @(negedge clk_i);
        checks++;
        if (status() !== 6'b0) $display("FAIL rstmid_rvalid: got %b expected %b", status(), 6'b0);
        else passes++;
        tick();
        bus_rvalid_i = 0;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk_i);
            model_eval();
            checks++;
            if (status() !== {e_req, e_igrant, e_dgrant, e_irv, e_drv, e_busy})
                $display("FAIL rand_status@%0d: got %b expected %b", cyc, status(),
                         {e_req, e_igrant, e_dgrant, e_irv, e_drv, e_busy});
            else passes++;
            if (e_req) begin
                checks++;
                if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== {e_we, e_be, e_addr, e_wdata})
                    $display("FAIL rand_fields@%0d: got %b %h %h %h expected %b %h %h %h", cyc,
                             bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, e_we, e_be, e_addr, e_wdata);
                else passes++;
            end
            if (e_irv) begin
                checks++;
                if (imem_rdata_o !== e_irdata)
                    $display("FAIL rand_irdata@%0d: got %h expected %h", cyc, imem_rdata_o, e_irdata);
                else passes++;
            end
            if (e_drv) begin
                checks++;
                if (dmem_rdata_o !== bus_rdata_i)
                    $display("FAIL rand_drdata@%0d: got %h expected %h", cyc, dmem_rdata_o, bus_rdata_i);
                else passes++;
            end
            tick();
            // Requesters hold until granted, then may raise a new request.
            if (!imem_req_i || e_igrant) begin
                imem_req_i  = ($urandom_range(0, 2) != 0);
                imem_addr_i = {$urandom, $urandom} & ~64'h3;
            end
            if (!dmem_req_i || e_dgrant) begin
                dmem_req_i   = ($urandom_range(0, 2) != 0);
                dmem_we_i    = $urandom_range(0, 1) == 1;
                dmem_be_i    = 8'($urandom);
                dmem_addr_i  = {$urandom, $urandom};
                dmem_wdata_i = {$urandom, $urandom};
            end
            bus_gnt_i    = $urandom_range(0, 1) == 1;
            bus_rvalid_i = $urandom_range(0, 2) == 0;
            bus_rdata_i  = {$urandom, $urandom};
            rst_i        = $urandom_range(0, 63) == 0;
        end
        rst_i = 0; imem_req_i = 0; dmem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
